// File: rtl/regfile_mp.sv
// regfile_mp: dual-write, dual-read register file with a post-reset
// clear sweep and a per-register pending bit, updated on negedge clk.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] datain,
  input  logic              wrt2,
  input  logic [ADDR_W-1:0] rd2,
  input  logic [DATA_W-1:0] datain2,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic [DATA_W-1:0] rsout,
  output logic [DATA_W-1:0] rtout,
  output logic              rs_pend,
  output logic              rt_pend,
  output logic              ready
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]        state;
  logic [IW-1:0]     ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic [DATA_W-1:0] rs_d;
  logic [DATA_W-1:0] rt_d;
  logic              wa;
  logic              wb;
  logic              bs;

  // Address is backed by a real, writable register
  function automatic logic ok(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] w;
    w = {1'b0, a};
    return (w < (ADDR_W+1)'(DEPTH)) &&
           !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [IW-1:0] ix(input logic [ADDR_W-1:0] a);
    return a[IW-1:0];
  endfunction

  assign wa    = (state == RUN) && wrt && ok(rd);
  assign wb    = (state == RUN) && wrt2 && ok(rd2);
  assign bs    = (state == RUN) && busy_set && ok(busy_addr);
  assign ready = (state == RUN);

  // Next pending vector: write clears first, then busy_set wins
  always_comb begin
    pend_nxt = pend;
    if (wa) pend_nxt[ix(rd)] = 1'b0;
    if (wb) pend_nxt[ix(rd2)] = 1'b0;
    if (bs) pend_nxt[ix(busy_addr)] = 1'b1;
  end

  // Write-first read data; port B overrides port A
  always_comb begin
    rs_d = mem[ix(rs)];
    rt_d = mem[ix(rt)];
    if (wa && (rd == rs)) rs_d = datain;
    if (wb && (rd2 == rs)) rs_d = datain2;
    if (wa && (rd == rt)) rt_d = datain;
    if (wb && (rd2 == rt)) rt_d = datain2;
    if (!ok(rs)) rs_d = '0;
    if (!ok(rt)) rt_d = '0;
  end

  // Storage: zero sweep in CLEAR, port A then port B in RUN
  always_ff @(negedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else begin
      if (wa) mem[ix(rd)] <= datain;
      if (wb) mem[ix(rd2)] <= datain2;
    end
  end

  // Control, pending bits and registered read outputs
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      ptr     <= '0;
      pend    <= '0;
      rsout   <= '0;
      rtout   <= '0;
      rs_pend <= 1'b0;
      rt_pend <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == CLEAR): begin
          pend    <= '0;
          rsout   <= '0;
          rtout   <= '0;
          rs_pend <= 1'b0;
          rt_pend <= 1'b0;
          if (ptr == IW'(DEPTH-1)) begin
            ptr   <= '0;
            state <= RUN;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        (state == RUN): begin
          pend    <= pend_nxt;
          rsout   <= rs_d;
          rtout   <= rt_d;
          rs_pend <= ok(rs) && pend_nxt[ix(rs)];
          rt_pend <= ok(rt) && pend_nxt[ix(rt)];
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table plus random traffic against a
// behavioural model, on a 64-entry and a 16-entry instance.
module tb_regfile_mp;

  logic        clk = 1'b1;
  logic        rst_n = 1'b0;
  logic        wrt, wrt2, busy_set;
  logic [5:0]  rd, rd2, rs, rt, busy_addr;
  logic [31:0] datain, datain2;

  logic [31:0] a_rsout, a_rtout, b_rsout, b_rtout;
  logic        a_rsp, a_rtp, a_rdy, b_rsp, b_rtp, b_rdy;

  int nvec = 0;
  int nbad = 0;

  logic [31:0] m_mem [2][64];
  bit          m_pend [2][64];
  bit          m_run [2];
  int          m_cnt [2];
  logic [31:0] e_rs [2];
  logic [31:0] e_rt [2];
  bit          e_rsp [2];
  bit          e_rtp [2];

  typedef struct {
    logic       w;
    logic [5:0] a;
    logic [31:0] d;
    logic       w2;
    logic [5:0] a2;
    logic [31:0] d2;
    logic [5:0] s;
    logic [5:0] t;
    logic       b;
    logic [5:0] ba;
    logic [31:0] ers;
    logic [31:0] ert;
    logic       esp;
    logic       etp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .DEPTH(64), .ADDR_W(6), .ZERO_REG(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .wrt(wrt), .rd(rd), .datain(datain),
    .wrt2(wrt2), .rd2(rd2), .datain2(datain2),
    .rs(rs), .rt(rt),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .rsout(a_rsout), .rtout(a_rtout),
    .rs_pend(a_rsp), .rt_pend(a_rtp), .ready(a_rdy)
  );

  regfile_mp #(.DATA_W(32), .DEPTH(16), .ADDR_W(6), .ZERO_REG(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .wrt(wrt), .rd(rd), .datain(datain),
    .wrt2(wrt2), .rd2(rd2), .datain2(datain2),
    .rs(rs), .rt(rt),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .rsout(b_rsout), .rtout(b_rtout),
    .rs_pend(b_rsp), .rt_pend(b_rtp), .ready(b_rdy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit mok(input int a, input int dep);
    return (a > 0) && (a < dep);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0;
      m_cnt[d] = 0;
      e_rs[d] = '0;
      e_rt[d] = '0;
      e_rsp[d] = 0;
      e_rtp[d] = 0;
      for (int i = 0; i < 64; i++) m_pend[d][i] = 0;
    end
  endtask

  task automatic model_edge(input int d);
    int dep;
    dep = (d == 0) ? 64 : 16;
    if (!m_run[d]) begin
      m_cnt[d]++;
      e_rs[d] = '0;
      e_rt[d] = '0;
      e_rsp[d] = 0;
      e_rtp[d] = 0;
      if (m_cnt[d] == dep) begin
        m_run[d] = 1;
        for (int i = 0; i < 64; i++) m_mem[d][i] = '0;
      end
      return;
    end
    if (wrt && mok(int'(rd), dep)) begin
      m_mem[d][rd] = datain;
      m_pend[d][rd] = 0;
    end
    if (wrt2 && mok(int'(rd2), dep)) begin
      m_mem[d][rd2] = datain2;
      m_pend[d][rd2] = 0;
    end
    if (busy_set && mok(int'(busy_addr), dep))
      m_pend[d][busy_addr] = 1;
    e_rs[d]  = mok(int'(rs), dep) ? m_mem[d][rs] : '0;
    e_rt[d]  = mok(int'(rt), dep) ? m_mem[d][rt] : '0;
    e_rsp[d] = mok(int'(rs), dep) ? m_pend[d][rs] : 1'b0;
    e_rtp[d] = mok(int'(rt), dep) ? m_pend[d][rt] : 1'b0;
  endtask

  task automatic check_model(input int d);
    logic [31:0] rso, rto;
    logic        rsp, rtp, rdy;
    rso = (d == 0) ? a_rsout : b_rsout;
    rto = (d == 0) ? a_rtout : b_rtout;
    rsp = (d == 0) ? a_rsp : b_rsp;
    rtp = (d == 0) ? a_rtp : b_rtp;
    rdy = (d == 0) ? a_rdy : b_rdy;
    chk($sformatf("d%0d_ready", d), 32'(rdy), 32'(m_run[d]));
    chk($sformatf("d%0d_rsout", d), rso, e_rs[d]);
    chk($sformatf("d%0d_rtout", d), rto, e_rt[d]);
    chk($sformatf("d%0d_rs_pend", d), 32'(rsp), 32'(e_rsp[d]));
    chk($sformatf("d%0d_rt_pend", d), 32'(rtp), 32'(e_rtp[d]));
  endtask

  task automatic set_idle();
    wrt = 0; rd = '0; datain = '0;
    wrt2 = 0; rd2 = '0; datain2 = '0;
    rs = '0; rt = '0;
    busy_set = 0; busy_addr = '0;
  endtask

  function automatic logic [5:0] raddr();
    if ($urandom_range(0, 2) == 0) return 6'($urandom_range(0, 63));
    return 6'($urandom_range(0, 15));
  endfunction

  task automatic set_rand();
    wrt = 1'($urandom); rd = raddr(); datain = $urandom;
    wrt2 = 1'($urandom); rd2 = raddr(); datain2 = $urandom;
    rs = raddr(); rt = raddr();
    busy_set = 1'($urandom); busy_addr = raddr();
  endtask

  task automatic edge_step();
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0;
    #2;
    model_reset();
    check_model(0);
    check_model(1);
    @(negedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic run_sweep(input int n);
    for (int i = 1; i <= n; i++) begin
      set_rand();
      if (i == 10) begin
        wrt = 1; rd = 6'd3; datain = 32'hFFFFFFFF;
        busy_set = 1; busy_addr = 6'd3;
      end
      edge_step();
      chk("sweep_ready", 32'(a_rdy), 32'(i >= 64));
      check_model(0);
      check_model(1);
    end
  endtask

  task automatic add(input int w, input int a, input logic [31:0] d,
                     input int w2, input int a2, input logic [31:0] d2,
                     input int s, input int t, input int b, input int ba,
                     input logic [31:0] ers, input logic [31:0] ert,
                     input int esp, input int etp);
    vec_t v;
    v.w = 1'(w); v.a = 6'(a); v.d = d;
    v.w2 = 1'(w2); v.a2 = 6'(a2); v.d2 = d2;
    v.s = 6'(s); v.t = 6'(t); v.b = 1'(b); v.ba = 6'(ba);
    v.ers = ers; v.ert = ert; v.esp = 1'(esp); v.etp = 1'(etp);
    tbl.push_back(v);
  endtask

  initial begin
    add(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0);
    add(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 32'hDEADBEEF, 0, 0);
    add(1, 7, 32'h11111111, 1, 7, 32'h22222222, 7, 0, 0, 0,
        32'h22222222, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 32'h22222222, 0, 0);
    add(0, 0, 0, 0, 0, 0, 9, 5, 1, 9, 0, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 1, 0);
    add(1, 9, 32'hA5A5A5A5, 0, 0, 0, 9, 0, 0, 0, 32'hA5A5A5A5, 0, 0, 0);
    add(0, 0, 0, 1, 9, 32'h77, 9, 0, 1, 9, 32'h77, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 32'h77, 32'h77, 1, 1);
    add(1, 20, 32'h55, 0, 0, 0, 20, 9, 1, 20, 32'h55, 32'h77, 1, 1);
    add(1, 0, 32'hABC, 0, 0, 0, 0, 20, 1, 0, 0, 32'h55, 0, 1);
    add(0, 0, 0, 0, 0, 0, 7, 5, 0, 0, 32'h22222222, 32'hDEADBEEF, 0, 0);

    set_idle();
    rst_n = 0;
    @(negedge clk);
    #1;
    model_reset();
    check_model(0);
    check_model(1);
    rst_n = 1;

    run_sweep(20);
    do_reset();
    run_sweep(64);

    for (int i = 0; i < 64; i++) begin
      set_idle();
      rs = 6'(i);
      rt = 6'(63 - i);
      edge_step();
      chk("clr_rsout", a_rsout, 32'h0);
      chk("clr_rtout", a_rtout, 32'h0);
      chk("clr_rs_pend", 32'(a_rsp), 32'h0);
      check_model(1);
    end

    foreach (tbl[k]) begin
      wrt = tbl[k].w; rd = tbl[k].a; datain = tbl[k].d;
      wrt2 = tbl[k].w2; rd2 = tbl[k].a2; datain2 = tbl[k].d2;
      rs = tbl[k].s; rt = tbl[k].t;
      busy_set = tbl[k].b; busy_addr = tbl[k].ba;
      edge_step();
      chk($sformatf("t%0d_rsout", k), a_rsout, tbl[k].ers);
      chk($sformatf("t%0d_rtout", k), a_rtout, tbl[k].ert);
      chk($sformatf("t%0d_rs_pend", k), 32'(a_rsp), 32'(tbl[k].esp));
      chk($sformatf("t%0d_rt_pend", k), 32'(a_rtp), 32'(tbl[k].etp));
      check_model(1);
    end

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        run_sweep(64);
      end
      set_rand();
      edge_step();
      check_model(0);
      check_model(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised dual-write, dual-read register file with a post-reset clear sweep and a per-register pending (scoreboard) bit. Sits in the decode/writeback stage of the datapath: the decoder reads rs/rt, the ALU writeback and load-return paths each own a write port, and issue logic marks destination registers pending. All state updates on the falling edge of `clk`, matching the datapath's negedge register-file timing.

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 64, number of registers (2..2^ADDR_W)
- ADDR_W, 6, address width
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never pending
- clk  in  1  clock; all state changes on negedge
- rst_n  in  1  asynchronous, active-low reset
- wrt  in  1  write enable, port A (ALU writeback)
- rd  in  ADDR_W  write address, port A
- datain  in  DATA_W  write data, port A
- wrt2  in  1  write enable, port B (load return)
- rd2  in  ADDR_W  write address, port B
- datain2  in  DATA_W  write data, port B
- rs  in  ADDR_W  read address 1
- rt  in  ADDR_W  read address 2
- busy_set  in  1  mark busy_addr pending
- busy_addr  in  ADDR_W  register being marked pending
- rsout  out  DATA_W  registered read data for rs
- rtout  out  DATA_W  registered read data for rt
- rs_pend  out  1  registered pending bit for rs
- rt_pend  out  1  registered pending bit for rt
- ready  out  1  high once the clear sweep is finished

## Operation
- States: CLEAR, RUN.
- rst_n low (asynchronous): state=CLEAR, sweep pointer=0, all pending bits=0, ready=0, rsout=rtout=0, rs_pend=rt_pend=0. Array contents are not reset directly.
- CLEAR: each negedge with rst_n high writes 0 to register[ptr] and increments ptr. The edge that writes entry DEPTH-1 sets ready=1 and moves to RUN. wrt, wrt2 and busy_set are ignored. Outputs stay 0.
- RUN, per negedge, in this order:
  - Writes: port A then port B. If both target the same address, port B data wins. Writes to address 0 are dropped when ZERO_REG=1. Writes to addresses >= DEPTH are dropped.
  - Pending: an accepted write clears pend[addr]. busy_set sets pend[busy_addr]. If a set and a clear hit the same address on the same edge, the set wins. The set is ignored for address 0 when ZERO_REG=1 and for addresses >= DEPTH.
  - Reads (write-first): rsout/rtout get the post-write contents of rs/rt. rs_pend/rt_pend get the post-update pending bits. Address 0 with ZERO_REG=1, or any address >= DEPTH, reads data 0 and pend 0.
- rst_n asserted mid-sweep or in RUN: return immediately to CLEAR. Pending bits are lost, and a full sweep restarts from ptr=0 after deassertion.

## Timing
- Read latency: the new value is visible on rsout/rtout right after the negedge at which rs/rt are sampled. The outputs hold until the next negedge.
- Write-to-read bypass: a write and a read of the same address on the same negedge return the written data (port B data if both ports write it).
- Sweep: exactly DEPTH negedges after rst_n deasserts, ready rises on the DEPTH-th. The first accepted write happens on the following negedge.
- A busy_set at edge n is seen on rs_pend at edge n if rs==busy_addr. The matching writeback at edge m>n clears it, and rs_pend=0 at edge m.
- No combinational path from any input to any output.

## Test plan
- Reset, then release: ready=0 for 63 negedges and 1 on the 64th. Reading all 64 addresses then returns 0x00000000 with pend=0. Pulse rst_n low at sweep count 20: ready stays 0, and a fresh 64-edge sweep follows.
- Write rd=5 data 0xDEADBEEF, then next edge read rs=5, rt=0: rsout=0xDEADBEEF, rtout=0. Write rd=0 data 0x1234: reading rs=0 returns 0.
- Same edge: wrt rd=7 data 0x11111111, wrt2 rd2=7 data 0x22222222, rs=7. rsout=0x22222222 on that edge. A later read also returns 0x22222222.
- busy_set busy_addr=9, rs=9: rs_pend=1. Two edges later wrt rd=9 data 0xA5A5A5A5: rs_pend=0 and rsout=0xA5A5A5A5 on that edge. Then busy_set=9 together with wrt2 rd2=9: rs_pend=1 and data is updated.
- During CLEAR, drive wrt rd=3 data 0xFFFFFFFF and busy_set=3. After ready, reading rs=3 returns 0 with pend=0.
- DEPTH=16, ADDR_W=6: write rd=20 data 0x55 and busy_set=20. Reading rs=20 returns 0 with pend=0, and registers 0..15 are unchanged.
